pool_pipo_ctrl: RTL and testbench



---
 rtl/pool_ctrl_pkg.sv | 21 ++
 rtl/pool_idx_counter.sv | 57 +++++
 rtl/pool_pipo_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pool_pipo_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_ctrl_pkg.sv
// Shared types and defaults for the pooling-stage PIPO row-buffer sequencer.
package pool_ctrl_pkg;

  localparam int ROW_W_DEF     = 8;
  localparam int MAP_W_DEF     = 8;
  localparam int POOL_ROWS_DEF = 2;
  localparam int TOT_W_DEF     = ROW_W_DEF + MAP_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER,
    PRESENT
  } state_e;

  // Width needed to count every row of a run (rows * maps).
  function automatic int tot_w(input int row_w, input int map_w);
    return row_w + map_w;
  endfunction

endpackage

// File: rtl/pool_idx_counter.sv
// Row/map wrapping position counter; row wraps at lim_row and bumps the map.
// Registered position, combinational last flags; clr has priority over en.
module pool_idx_counter
  import pool_ctrl_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int MAP_W = MAP_W_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             en,
  input  logic [ROW_W-1:0] lim_row,
  input  logic [MAP_W-1:0] lim_map,
  output logic [ROW_W-1:0] row,
  output logic [MAP_W-1:0] map,
  output logic             last_row,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [MAP_W-1:0] map_q, map_d;
  logic             last_map;

  assign last_row = (row_q == lim_row);
  assign last_map = (map_q == lim_map);
  assign last     = last_row && last_map;
  assign row      = row_q;
  assign map      = map_q;

  always_comb begin
    row_d = row_q;
    map_d = map_q;
    if (clr) begin
      row_d = '0;
      map_d = '0;
    end else if (en) begin
      if (last_row) begin
        row_d = '0;
        map_d = last_map ? '0 : map_q + MAP_W'(1);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_q <= '0;
      map_q <= '0;
    end else begin
      row_q <= row_d;
      map_q <= map_d;
    end
  end

endmodule

// File: rtl/pool_pipo_ctrl.sv
// Sequences PIPO wr_ctrl/r_ctrl strobes and presents rows to max-pool; accept->present is 2 cycles.
// Upstream stalls (row_ready low) once one row is held behind the presented row.
module pool_pipo_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int ROW_W     = ROW_W_DEF,
  parameter int MAP_W     = MAP_W_DEF,
  parameter int POOL_ROWS = POOL_ROWS_DEF
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic [ROW_W-1:0]             cfg_rows,
  input  logic [MAP_W-1:0]             cfg_maps,
  input  logic                         row_valid,
  output logic                         row_ready,
  output logic                         wr_ctrl,
  output logic                         r_ctrl,
  output logic                         pool_valid,
  input  logic                         pool_ready,
  output logic [$clog2(POOL_ROWS)-1:0] row_sel,
  output logic                         last_row,
  output logic                         busy,
  output logic                         done
);

  localparam int SEL_W = $clog2(POOL_ROWS);
  localparam int TOT_W = tot_w(ROW_W, MAP_W);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [MAP_W-1:0] maps_q, maps_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TOT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             reg_full_q, reg_full_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] row_sel_q, row_sel_d;
  logic             last_row_q, last_row_d;

  logic             cnt_clr;
  logic             pr_en;
  logic             rows_pending;

  logic [ROW_W-1:0] acc_row, pr_row;
  logic [MAP_W-1:0] acc_map, pr_map;
  logic             acc_last_row, acc_last, pr_last_row, pr_last;
  logic             unused_idx;

  assign rows_pending = (acc_cnt_q < tot_q);
  assign wr_ctrl      = row_valid && row_ready;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign row_sel      = row_sel_q;
  assign last_row     = last_row_q;
  assign unused_idx   = ^{acc_row, acc_map, acc_last_row, acc_last, pr_map, pr_last};

  pool_idx_counter #(.ROW_W(ROW_W), .MAP_W(MAP_W)) u_acc_cnt (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (cnt_clr),
    .en       (wr_ctrl),
    .lim_row  (rows_q - ROW_W'(1)),
    .lim_map  (maps_q - MAP_W'(1)),
    .row      (acc_row),
    .map      (acc_map),
    .last_row (acc_last_row),
    .last     (acc_last)
  );

  pool_idx_counter #(.ROW_W(ROW_W), .MAP_W(MAP_W)) u_pr_cnt (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (cnt_clr),
    .en       (pr_en),
    .lim_row  (rows_q - ROW_W'(1)),
    .lim_map  (maps_q - MAP_W'(1)),
    .row      (pr_row),
    .map      (pr_map),
    .last_row (pr_last_row),
    .last     (pr_last)
  );

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    maps_d     = maps_q;
    tot_d      = tot_q;
    acc_cnt_d  = acc_cnt_q;
    reg_full_d = reg_full_q;
    done_d     = 1'b0;
    row_sel_d  = row_sel_q;
    last_row_d = last_row_q;
    cnt_clr    = 1'b0;
    pr_en      = 1'b0;
    row_ready  = 1'b0;
    r_ctrl     = 1'b0;
    pool_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d     = cfg_rows;
          maps_d     = cfg_maps;
          tot_d      = TOT_W'(cfg_rows) * TOT_W'(cfg_maps);
          acc_cnt_d  = '0;
          reg_full_d = 1'b0;
          cnt_clr    = 1'b1;
          // An empty run completes immediately without leaving IDLE.
          if (cfg_rows == '0 || cfg_maps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        row_ready = 1'b1;
        if (row_valid) begin
          state_d = XFER;
        end
      end

      XFER: begin
        r_ctrl     = 1'b1;
        reg_full_d = 1'b0;
        pr_en      = 1'b1;
        row_sel_d  = SEL_W'(pr_row % ROW_W'(POOL_ROWS));
        last_row_d = pr_last_row;
        state_d    = PRESENT;
      end

      PRESENT: begin
        pool_valid = 1'b1;
        // Capture at most one row behind the one being presented.
        row_ready  = !reg_full_q && rows_pending;
        if (row_valid && row_ready) begin
          reg_full_d = 1'b1;
        end
        if (pool_ready) begin
          if (reg_full_q || (row_valid && row_ready)) begin
            state_d = XFER;
          end else if (rows_pending) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (row_valid && row_ready) begin
      acc_cnt_d = acc_cnt_q + TOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      maps_q     <= '0;
      tot_q      <= '0;
      acc_cnt_q  <= '0;
      reg_full_q <= 1'b0;
      done_q     <= 1'b0;
      row_sel_q  <= '0;
      last_row_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      maps_q     <= maps_d;
      tot_q      <= tot_d;
      acc_cnt_q  <= acc_cnt_d;
      reg_full_q <= reg_full_d;
      done_q     <= done_d;
      row_sel_q  <= row_sel_d;
      last_row_q <= last_row_d;
    end
  end

endmodule

// File: tb/tb_pool_pipo_ctrl.sv
// Bench for pool_pipo_ctrl: models the PIPO buffer and upstream row source, checks row order and tags.
module tb_pool_pipo_ctrl;

  localparam int PR = 2;

  logic       clk;
  logic       nrst;
  logic       start;
  logic [7:0] cfg_rows;
  logic [7:0] cfg_maps;
  logic       row_valid;
  logic       row_ready;
  logic       wr_ctrl;
  logic       r_ctrl;
  logic       pool_valid;
  logic       pool_ready;
  logic [0:0] row_sel;
  logic       last_row;
  logic       busy;
  logic       done;

  pool_pipo_ctrl #(.ROW_W(8), .MAP_W(8), .POOL_ROWS(PR)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .cfg_maps   (cfg_maps),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .wr_ctrl    (wr_ctrl),
    .r_ctrl     (r_ctrl),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .row_sel    (row_sel),
    .last_row   (last_row),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Run-scoped reference state
  int send_id, in_reg, out_reg;
  int n_wr, n_r, n_pres, n_done, busy_seen;
  int first_hs, last_hs, done_cyc, start_cyc;
  int cur_rows, cur_total, cur_mode;
  int stall_cnt;
  logic       prev_pv, prev_pr, prev_last;
  logic [0:0] prev_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      prev_pv = 1'b0;
      prev_pr = 1'b0;
    end else begin
      chk("strobe_excl", 32'(wr_ctrl && r_ctrl), 32'd0);
      if (busy) busy_seen++;
      if (wr_ctrl) begin
        in_reg = send_id;
        send_id++;
        n_wr++;
      end
      if (r_ctrl) begin
        out_reg = in_reg;
        n_r++;
      end
      if (prev_pv && !prev_pr) begin
        chk("hold_valid", 32'(pool_valid), 32'd1);
        chk("hold_sel", 32'(row_sel), 32'(prev_sel));
        chk("hold_last", 32'(last_row), 32'(prev_last));
      end
      if (pool_valid && pool_ready) begin
        int k, rin, ahead;
        k   = n_pres;
        rin = (cur_rows > 0) ? k % cur_rows : 0;
        chk("row_order", out_reg, k);
        chk("row_sel", 32'(row_sel), rin % PR);
        chk("last_row", 32'(last_row), 32'(rin == cur_rows - 1));
        if (cur_mode != 1) begin
          ahead = (k + 2 < cur_total) ? k + 2 : cur_total;
          chk("accepted_ahead", n_wr, ahead);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        n_pres++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_pv   = pool_valid;
      prev_pr   = pool_ready;
      prev_sel  = row_sel;
      prev_last = last_row;
    end
    cyc++;
  end

  task automatic begin_run(input int rows, input int maps, input int mode);
    send_id = 0; in_reg = -1; out_reg = -1;
    n_wr = 0; n_r = 0; n_pres = 0; n_done = 0; busy_seen = 0;
    first_hs = -1; last_hs = -1; done_cyc = -1;
    cur_rows = rows; cur_total = rows * maps; cur_mode = mode;
    stall_cnt = 0;
  endtask

  // mode 0: always valid/ready, 1: random 50%, 2: ready held low 5 cycles per row
  task automatic drive(input int mode);
    row_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mode == 0) begin
      pool_ready = 1'b1;
    end else if (mode == 1) begin
      pool_ready = 1'($urandom_range(0, 1));
    end else if (pool_valid) begin
      if (stall_cnt == 5) begin
        pool_ready = 1'b1;
        stall_cnt  = 0;
      end else begin
        pool_ready = 1'b0;
        stall_cnt++;
      end
    end else begin
      pool_ready = 1'b0;
    end
  endtask

  task automatic run(input int rows, input int maps, input int mode, input int restart_at,
                     input string tag);
    begin_run(rows, maps, mode);
    @(posedge clk); #1;
    cfg_rows  = 8'(rows);
    cfg_maps  = 8'(maps);
    start     = 1'b1;
    start_cyc = cyc;
    drive(mode);
    for (int i = 0; i < 3000 && n_done == 0; i++) begin
      @(posedge clk); #1;
      start = (i == restart_at);
      if (start) begin
        cfg_rows = 8'd5;
        cfg_maps = 8'd2;
      end
      drive(mode);
    end
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      drive(mode);
    end
    chk({tag, "_presented"}, n_pres, cur_total);
    chk({tag, "_accepted"}, n_wr, cur_total);
    chk({tag, "_xfers"}, n_r, cur_total);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (cur_total == 0) begin
      chk({tag, "_done_lat"}, done_cyc, start_cyc + 1);
      chk({tag, "_busy_seen"}, busy_seen, 0);
    end else begin
      chk({tag, "_done_lat"}, done_cyc, last_hs + 1);
      if (mode == 0) begin
        chk({tag, "_first_lat"}, first_hs, start_cyc + 3);
        chk({tag, "_throughput"}, last_hs, start_cyc + 1 + 2 * cur_total);
      end
    end
  endtask

  initial begin
    nrst       = 1'b0;
    start      = 1'b0;
    cfg_rows   = 8'd0;
    cfg_maps   = 8'd0;
    row_valid  = 1'b1;
    pool_ready = 1'b1;
    begin_run(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_ready", 32'(row_ready), 32'd0);
    chk("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("rst_r_ctrl", 32'(r_ctrl), 32'd0);
    chk("rst_pool_valid", 32'(pool_valid), 32'd0);
    chk("rst_row_sel", 32'(row_sel), 32'd0);
    chk("rst_last_row", 32'(last_row), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    nrst = 1'b1;

    run(4, 1, 0, -1, "full_4x1");
    run(3, 2, 2, -1, "stall_3x2");
    run(0, 3, 0, -1, "zero_rows");
    run(5, 0, 0, -1, "zero_maps");
    run(3, 1, 0, 2, "restart_ignored");

    // Abort with reset while a row transfer is in flight
    begin_run(4, 2, 0);
    @(posedge clk); #1;
    cfg_rows = 8'd4;
    cfg_maps = 8'd2;
    start    = 1'b1;
    for (int i = 0; i < 20 && !r_ctrl; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
    chk("abort_in_xfer", 32'(r_ctrl), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("abort_r_ctrl", 32'(r_ctrl), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pool_valid", 32'(pool_valid), 32'd0);
    chk("abort_row_ready", 32'(row_ready), 32'd0);
    chk("abort_wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", n_done, 0);
    chk("abort_idle", 32'(busy), 32'd0);
    run(2, 2, 0, -1, "fresh_after_abort");

    run(7, 3, 1, -1, "random_7x3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
